// File: rtl/rt_track_pipe_pkg.sv
// Shared definitions for the rt destination-tracking pipeline.
// Holds the pipeline geometry, the unit-index encoding, the per-pipe
// legal-index masks and the stage entry type.
package rt_track_pipe_pkg;

    localparam int NSTAGE = 7;
    localparam int ADDR_W = 7;
    localparam int IDX_W  = 3;

    localparam logic [IDX_W-1:0] IDX_NONE   = 3'd0;
    localparam logic [IDX_W-1:0] IDX_SIMPLE = 3'd1;
    localparam logic [IDX_W-1:0] IDX_BYTE   = 3'd2;
    localparam logic [IDX_W-1:0] IDX_SPFP   = 3'd3;
    localparam logic [IDX_W-1:0] IDX_PERM2  = 3'd4;
    localparam logic [IDX_W-1:0] IDX_PERM   = 3'd5;
    localparam logic [IDX_W-1:0] IDX_LS     = 3'd6;
    localparam logic [IDX_W-1:0] IDX_DPMUL  = 3'd7;

    // Bit n set means unit index n may be issued on that pipe.
    // Index 0 (no write) is legal on both pipes.
    localparam logic [(1<<IDX_W)-1:0] EP_LEGAL_MASK = 8'b1001_1111;
    localparam logic [(1<<IDX_W)-1:0] OP_LEGAL_MASK = 8'b0110_0001;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [IDX_W-1:0]  idx;
    } rt_entry_t;

    function automatic logic idx_legal(input logic [IDX_W-1:0] idx,
                                       input logic [(1<<IDX_W)-1:0] mask);
        return mask[idx];
    endfunction

endpackage

// File: rtl/rt_stage_chain.sv
// NSTAGE-deep shift register of rt entries for one issue pipe.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load_en         stage 1 takes load_entry when set, a bubble otherwise
//   load_entry      entry presented by the issuing instruction
//   stage[0..N-1]   registered entries, stage[0] is pipeline stage 1
module rt_stage_chain
    import rt_track_pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load_en,
    input  rt_entry_t load_entry,
    output rt_entry_t stage [NSTAGE]
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSTAGE; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= load_en ? load_entry : '0;
            // Older stages always advance; nothing downstream can be killed.
            for (int i = 1; i < NSTAGE; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

endmodule

// File: rtl/rt_track_pipe.sv
// Destination-tracking pipeline for the dual-issue SPU.
// Tracks rt/unit-index of every instruction issued on the even (ep) and
// odd (op) pipes through 7 stages and requests register-file writeback
// from stage 7.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   issue_{rt,idx,wr}_{ep,op}      issuing instruction per pipe
//   flush                          kills the pair issuing this cycle
//   rf_addr_sN_*, rf_idx_sN_*      registered stage N contents (N=1..7)
//   wb_en_*, wb_addr_*             stage-7 writeback request
//   waw_err, idx_err               sticky error flags
module rt_track_pipe
    import rt_track_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] issue_rt_ep,
    input  logic [IDX_W-1:0]  issue_idx_ep,
    input  logic              issue_wr_ep,
    input  logic [ADDR_W-1:0] issue_rt_op,
    input  logic [IDX_W-1:0]  issue_idx_op,
    input  logic              issue_wr_op,
    input  logic              flush,
    output logic [ADDR_W-1:0] rf_addr_s1_ep, rf_addr_s2_ep, rf_addr_s3_ep, rf_addr_s4_ep,
    output logic [ADDR_W-1:0] rf_addr_s5_ep, rf_addr_s6_ep, rf_addr_s7_ep,
    output logic [IDX_W-1:0]  rf_idx_s1_ep, rf_idx_s2_ep, rf_idx_s3_ep, rf_idx_s4_ep,
    output logic [IDX_W-1:0]  rf_idx_s5_ep, rf_idx_s6_ep, rf_idx_s7_ep,
    output logic [ADDR_W-1:0] rf_addr_s1_op, rf_addr_s2_op, rf_addr_s3_op, rf_addr_s4_op,
    output logic [ADDR_W-1:0] rf_addr_s5_op, rf_addr_s6_op, rf_addr_s7_op,
    output logic [IDX_W-1:0]  rf_idx_s1_op, rf_idx_s2_op, rf_idx_s3_op, rf_idx_s4_op,
    output logic [IDX_W-1:0]  rf_idx_s5_op, rf_idx_s6_op, rf_idx_s7_op,
    output logic              wb_en_ep,
    output logic              wb_en_op,
    output logic [ADDR_W-1:0] wb_addr_ep,
    output logic [ADDR_W-1:0] wb_addr_op,
    output logic              waw_err,
    output logic              idx_err
);

    rt_entry_t ep_s [NSTAGE];
    rt_entry_t op_s [NSTAGE];

    logic legal_ep, legal_op;
    logic load_ep, load_op;
    logic bad_ep, bad_op;
    logic waw_hit;

    assign legal_ep = idx_legal(issue_idx_ep, EP_LEGAL_MASK);
    assign legal_op = idx_legal(issue_idx_op, OP_LEGAL_MASK);

    assign load_ep = !flush && issue_wr_ep && legal_ep;
    assign load_op = !flush && issue_wr_op && legal_op;

    // Flushed instructions never raise errors.
    assign bad_ep  = !flush && issue_wr_ep && !legal_ep;
    assign bad_op  = !flush && issue_wr_op && !legal_op;
    assign waw_hit = load_ep && load_op && (issue_rt_ep == issue_rt_op);

    rt_stage_chain u_chain_ep (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_ep),
        .load_entry ('{addr: issue_rt_ep, idx: issue_idx_ep}),
        .stage      (ep_s)
    );

    rt_stage_chain u_chain_op (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_op),
        .load_entry ('{addr: issue_rt_op, idx: issue_idx_op}),
        .stage      (op_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waw_err <= 1'b0;
            idx_err <= 1'b0;
        end else begin
            if (waw_hit)         waw_err <= 1'b1;
            if (bad_ep || bad_op) idx_err <= 1'b1;
        end
    end

    assign rf_addr_s1_ep = ep_s[0].addr;  assign rf_idx_s1_ep = ep_s[0].idx;
    assign rf_addr_s2_ep = ep_s[1].addr;  assign rf_idx_s2_ep = ep_s[1].idx;
    assign rf_addr_s3_ep = ep_s[2].addr;  assign rf_idx_s3_ep = ep_s[2].idx;
    assign rf_addr_s4_ep = ep_s[3].addr;  assign rf_idx_s4_ep = ep_s[3].idx;
    assign rf_addr_s5_ep = ep_s[4].addr;  assign rf_idx_s5_ep = ep_s[4].idx;
    assign rf_addr_s6_ep = ep_s[5].addr;  assign rf_idx_s6_ep = ep_s[5].idx;
    assign rf_addr_s7_ep = ep_s[6].addr;  assign rf_idx_s7_ep = ep_s[6].idx;

    assign rf_addr_s1_op = op_s[0].addr;  assign rf_idx_s1_op = op_s[0].idx;
    assign rf_addr_s2_op = op_s[1].addr;  assign rf_idx_s2_op = op_s[1].idx;
    assign rf_addr_s3_op = op_s[2].addr;  assign rf_idx_s3_op = op_s[2].idx;
    assign rf_addr_s4_op = op_s[3].addr;  assign rf_idx_s4_op = op_s[3].idx;
    assign rf_addr_s5_op = op_s[4].addr;  assign rf_idx_s5_op = op_s[4].idx;
    assign rf_addr_s6_op = op_s[5].addr;  assign rf_idx_s6_op = op_s[5].idx;
    assign rf_addr_s7_op = op_s[6].addr;  assign rf_idx_s7_op = op_s[6].idx;

    // Same-register writeback collision: the odd pipe wins.
    assign wb_en_op   = (op_s[NSTAGE-1].idx != IDX_NONE);
    assign wb_en_ep   = (ep_s[NSTAGE-1].idx != IDX_NONE) &&
                        !(wb_en_op && (ep_s[NSTAGE-1].addr == op_s[NSTAGE-1].addr));
    assign wb_addr_ep = ep_s[NSTAGE-1].addr;
    assign wb_addr_op = op_s[NSTAGE-1].addr;

endmodule

// File: tb/tb_rt_track_pipe.sv
// Directed testbench for rt_track_pipe.
module tb_rt_track_pipe;

    logic       clk;
    logic       rst;
    logic [6:0] issue_rt_ep, issue_rt_op;
    logic [2:0] issue_idx_ep, issue_idx_op;
    logic       issue_wr_ep, issue_wr_op;
    logic       flush;

    logic [6:0] rf_addr_s1_ep, rf_addr_s2_ep, rf_addr_s3_ep, rf_addr_s4_ep;
    logic [6:0] rf_addr_s5_ep, rf_addr_s6_ep, rf_addr_s7_ep;
    logic [2:0] rf_idx_s1_ep, rf_idx_s2_ep, rf_idx_s3_ep, rf_idx_s4_ep;
    logic [2:0] rf_idx_s5_ep, rf_idx_s6_ep, rf_idx_s7_ep;
    logic [6:0] rf_addr_s1_op, rf_addr_s2_op, rf_addr_s3_op, rf_addr_s4_op;
    logic [6:0] rf_addr_s5_op, rf_addr_s6_op, rf_addr_s7_op;
    logic [2:0] rf_idx_s1_op, rf_idx_s2_op, rf_idx_s3_op, rf_idx_s4_op;
    logic [2:0] rf_idx_s5_op, rf_idx_s6_op, rf_idx_s7_op;
    logic       wb_en_ep, wb_en_op;
    logic [6:0] wb_addr_ep, wb_addr_op;
    logic       waw_err, idx_err;

    int checks = 0;
    int failures = 0;

    logic [6:0] ep_addr [1:7];
    logic [2:0] ep_idx  [1:7];
    logic [6:0] op_addr [1:7];
    logic [2:0] op_idx  [1:7];

    assign ep_addr[1] = rf_addr_s1_ep; assign ep_idx[1] = rf_idx_s1_ep;
    assign ep_addr[2] = rf_addr_s2_ep; assign ep_idx[2] = rf_idx_s2_ep;
    assign ep_addr[3] = rf_addr_s3_ep; assign ep_idx[3] = rf_idx_s3_ep;
    assign ep_addr[4] = rf_addr_s4_ep; assign ep_idx[4] = rf_idx_s4_ep;
    assign ep_addr[5] = rf_addr_s5_ep; assign ep_idx[5] = rf_idx_s5_ep;
    assign ep_addr[6] = rf_addr_s6_ep; assign ep_idx[6] = rf_idx_s6_ep;
    assign ep_addr[7] = rf_addr_s7_ep; assign ep_idx[7] = rf_idx_s7_ep;
    assign op_addr[1] = rf_addr_s1_op; assign op_idx[1] = rf_idx_s1_op;
    assign op_addr[2] = rf_addr_s2_op; assign op_idx[2] = rf_idx_s2_op;
    assign op_addr[3] = rf_addr_s3_op; assign op_idx[3] = rf_idx_s3_op;
    assign op_addr[4] = rf_addr_s4_op; assign op_idx[4] = rf_idx_s4_op;
    assign op_addr[5] = rf_addr_s5_op; assign op_idx[5] = rf_idx_s5_op;
    assign op_addr[6] = rf_addr_s6_op; assign op_idx[6] = rf_idx_s6_op;
    assign op_addr[7] = rf_addr_s7_op; assign op_idx[7] = rf_idx_s7_op;

    rt_track_pipe dut (
        .clk(clk), .rst(rst),
        .issue_rt_ep(issue_rt_ep), .issue_idx_ep(issue_idx_ep), .issue_wr_ep(issue_wr_ep),
        .issue_rt_op(issue_rt_op), .issue_idx_op(issue_idx_op), .issue_wr_op(issue_wr_op),
        .flush(flush),
        .rf_addr_s1_ep(rf_addr_s1_ep), .rf_addr_s2_ep(rf_addr_s2_ep), .rf_addr_s3_ep(rf_addr_s3_ep),
        .rf_addr_s4_ep(rf_addr_s4_ep), .rf_addr_s5_ep(rf_addr_s5_ep), .rf_addr_s6_ep(rf_addr_s6_ep),
        .rf_addr_s7_ep(rf_addr_s7_ep),
        .rf_idx_s1_ep(rf_idx_s1_ep), .rf_idx_s2_ep(rf_idx_s2_ep), .rf_idx_s3_ep(rf_idx_s3_ep),
        .rf_idx_s4_ep(rf_idx_s4_ep), .rf_idx_s5_ep(rf_idx_s5_ep), .rf_idx_s6_ep(rf_idx_s6_ep),
        .rf_idx_s7_ep(rf_idx_s7_ep),
        .rf_addr_s1_op(rf_addr_s1_op), .rf_addr_s2_op(rf_addr_s2_op), .rf_addr_s3_op(rf_addr_s3_op),
        .rf_addr_s4_op(rf_addr_s4_op), .rf_addr_s5_op(rf_addr_s5_op), .rf_addr_s6_op(rf_addr_s6_op),
        .rf_addr_s7_op(rf_addr_s7_op),
        .rf_idx_s1_op(rf_idx_s1_op), .rf_idx_s2_op(rf_idx_s2_op), .rf_idx_s3_op(rf_idx_s3_op),
        .rf_idx_s4_op(rf_idx_s4_op), .rf_idx_s5_op(rf_idx_s5_op), .rf_idx_s6_op(rf_idx_s6_op),
        .rf_idx_s7_op(rf_idx_s7_op),
        .wb_en_ep(wb_en_ep), .wb_en_op(wb_en_op),
        .wb_addr_ep(wb_addr_ep), .wb_addr_op(wb_addr_op),
        .waw_err(waw_err), .idx_err(idx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        issue_rt_ep = '0; issue_idx_ep = '0; issue_wr_ep = 1'b0;
        issue_rt_op = '0; issue_idx_op = '0; issue_wr_op = 1'b0;
        flush = 1'b0;
    endtask

    task automatic issue_ep(input logic [6:0] rt, input logic [2:0] idx, input logic wr);
        issue_rt_ep = rt; issue_idx_ep = idx; issue_wr_ep = wr;
    endtask

    task automatic issue_op(input logic [6:0] rt, input logic [2:0] idx, input logic wr);
        issue_rt_op = rt; issue_idx_op = idx; issue_wr_op = wr;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #3;
        for (int n = 1; n <= 7; n++) begin
            checks++;
            if ({ep_addr[n], ep_idx[n], op_addr[n], op_idx[n]} !== 20'd0) begin
                failures++;
                $display("FAIL reset_stage%0d got ep=%0d/%0d op=%0d/%0d want 0", n,
                         ep_addr[n], ep_idx[n], op_addr[n], op_idx[n]);
            end
        end
        checks++;
        if ({wb_en_ep, wb_en_op, wb_addr_ep, wb_addr_op, waw_err, idx_err} !== 18'd0) begin
            failures++;
            $display("FAIL reset_wb_flags got wb=%b%b %0d %0d waw=%b idx=%b want 0",
                     wb_en_ep, wb_en_op, wb_addr_ep, wb_addr_op, waw_err, idx_err);
        end
        tick(2);
        rst = 1'b1;
    endtask

    task automatic test_single();
        issue_ep(7'd10, 3'd1, 1'b1);
        tick(1);
        idle();
        checks++;
        if (rf_addr_s1_ep !== 7'd10 || rf_idx_s1_ep !== 3'd1) begin
            failures++;
            $display("FAIL single_s1 got %0d/%0d want 10/1", rf_addr_s1_ep, rf_idx_s1_ep);
        end
        checks++;
        if (wb_en_ep !== 1'b0) begin
            failures++;
            $display("FAIL single_no_early_wb got %b want 0", wb_en_ep);
        end
        tick(6);
        checks++;
        if (wb_en_ep !== 1'b1 || wb_addr_ep !== 7'd10 || rf_idx_s7_ep !== 3'd1) begin
            failures++;
            $display("FAIL single_wb got en=%b addr=%0d idx7=%0d want 1/10/1",
                     wb_en_ep, wb_addr_ep, rf_idx_s7_ep);
        end
        tick(1);
        checks++;
        if (wb_en_ep !== 1'b0) begin
            failures++;
            $display("FAIL single_wb_once got %b want 0", wb_en_ep);
        end
    endtask

    task automatic test_flush();
        issue_ep(7'd5, 3'd3, 1'b1);
        issue_op(7'd6, 3'd6, 1'b1);
        tick(1);
        checks++;
        if (rf_addr_s1_ep !== 7'd5 || rf_idx_s1_ep !== 3'd3 ||
            rf_addr_s1_op !== 7'd6 || rf_idx_s1_op !== 3'd6) begin
            failures++;
            $display("FAIL flush_pair_s1 got ep=%0d/%0d op=%0d/%0d want 5/3 6/6",
                     rf_addr_s1_ep, rf_idx_s1_ep, rf_addr_s1_op, rf_idx_s1_op);
        end
        issue_ep(7'd7, 3'd1, 1'b1);
        issue_op(7'd7, 3'd5, 1'b1);
        flush = 1'b1;
        tick(1);
        idle();
        checks++;
        if (rf_idx_s1_ep !== 3'd0 || rf_idx_s1_op !== 3'd0 || rf_addr_s1_ep !== 7'd0 ||
            rf_addr_s2_ep !== 7'd5 || rf_addr_s2_op !== 7'd6) begin
            failures++;
            $display("FAIL flush_kill got s1 idx=%0d/%0d addr=%0d s2=%0d/%0d want 0/0 0 5/6",
                     rf_idx_s1_ep, rf_idx_s1_op, rf_addr_s1_ep, rf_addr_s2_ep, rf_addr_s2_op);
        end
        checks++;
        if (waw_err !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_waw got %b want 0", waw_err);
        end
        tick(5);
        checks++;
        if (wb_en_ep !== 1'b1 || wb_addr_ep !== 7'd5 || wb_en_op !== 1'b1 || wb_addr_op !== 7'd6) begin
            failures++;
            $display("FAIL flush_older_wb got ep=%b/%0d op=%b/%0d want 1/5 1/6",
                     wb_en_ep, wb_addr_ep, wb_en_op, wb_addr_op);
        end
        tick(1);
        checks++;
        if (wb_en_ep !== 1'b0 || wb_en_op !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_wb got %b/%b want 0/0", wb_en_ep, wb_en_op);
        end
    endtask

    task automatic test_idx_err();
        issue_op(7'd12, 3'd2, 1'b1);
        flush = 1'b1;
        tick(1);
        checks++;
        if (idx_err !== 1'b0) begin
            failures++;
            $display("FAIL idx_err_flushed got %b want 0", idx_err);
        end
        flush = 1'b0;
        tick(1);
        idle();
        checks++;
        if (rf_idx_s1_op !== 3'd0 || rf_addr_s1_op !== 7'd0 || idx_err !== 1'b1) begin
            failures++;
            $display("FAIL idx_err_set got s1_op=%0d/%0d err=%b want 0/0 1",
                     rf_addr_s1_op, rf_idx_s1_op, idx_err);
        end
        // odd-only index on the even pipe is also illegal but must not clear anything
        tick(4);
        checks++;
        if (idx_err !== 1'b1) begin
            failures++;
            $display("FAIL idx_err_sticky got %b want 1", idx_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (idx_err !== 1'b0) begin
            failures++;
            $display("FAIL idx_err_reset got %b want 0", idx_err);
        end
        tick(1);
        rst = 1'b1;
        issue_ep(7'd13, 3'd5, 1'b1);
        tick(1);
        idle();
        checks++;
        if (rf_idx_s1_ep !== 3'd0 || idx_err !== 1'b1) begin
            failures++;
            $display("FAIL idx_err_ep got s1 idx=%0d err=%b want 0 1", rf_idx_s1_ep, idx_err);
        end
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
    endtask

    task automatic test_waw();
        issue_ep(7'd20, 3'd1, 1'b1);
        issue_op(7'd20, 3'd5, 1'b1);
        tick(1);
        idle();
        checks++;
        if (waw_err !== 1'b1 || idx_err !== 1'b0) begin
            failures++;
            $display("FAIL waw_set got waw=%b idx=%b want 1 0", waw_err, idx_err);
        end
        tick(6);
        checks++;
        if (wb_en_op !== 1'b1 || wb_addr_op !== 7'd20 || wb_en_ep !== 1'b0 ||
            rf_idx_s7_ep !== 3'd1 || rf_addr_s7_ep !== 7'd20) begin
            failures++;
            $display("FAIL waw_wb got op=%b/%0d ep=%b s7_ep=%0d/%0d want 1/20 0 20/1",
                     wb_en_op, wb_addr_op, wb_en_ep, rf_addr_s7_ep, rf_idx_s7_ep);
        end
        tick(1);
        checks++;
        if (waw_err !== 1'b1) begin
            failures++;
            $display("FAIL waw_sticky got %b want 1", waw_err);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 3; r <= 9; r++) begin
            issue_ep(7'(r), 3'd7, 1'b1);
            tick(1);
        end
        idle();
        for (int n = 1; n <= 7; n++) begin
            checks++;
            if (ep_addr[n] !== 7'(10 - n) || ep_idx[n] !== 3'd7) begin
                failures++;
                $display("FAIL stream_s%0d got %0d/%0d want %0d/7", n, ep_addr[n], ep_idx[n], 10 - n);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        for (int n = 1; n <= 7; n++) begin
            checks++;
            if ({ep_addr[n], ep_idx[n], op_addr[n], op_idx[n]} !== 20'd0) begin
                failures++;
                $display("FAIL async_rst_s%0d got ep=%0d/%0d op=%0d/%0d want 0", n,
                         ep_addr[n], ep_idx[n], op_addr[n], op_idx[n]);
            end
        end
        checks++;
        if ({wb_en_ep, wb_en_op, waw_err, idx_err} !== 4'd0) begin
            failures++;
            $display("FAIL async_rst_flags got wb=%b%b waw=%b idx=%b want 0",
                     wb_en_ep, wb_en_op, waw_err, idx_err);
        end
        tick(1);
        issue_ep(7'd33, 3'd2, 1'b1);
        rst = 1'b1;
        tick(1);
        idle();
        checks++;
        if (rf_addr_s1_ep !== 7'd33 || rf_idx_s1_ep !== 3'd2 || rf_idx_s2_ep !== 3'd0) begin
            failures++;
            $display("FAIL post_rst_issue got s1=%0d/%0d s2 idx=%0d want 33/2 0",
                     rf_addr_s1_ep, rf_idx_s1_ep, rf_idx_s2_ep);
        end
        tick(6);
    endtask

    task automatic test_no_write();
        issue_ep(7'd11, 3'd4, 1'b0);
        tick(1);
        issue_ep(7'd0, 3'd2, 1'b1);
        tick(1);
        idle();
        checks++;
        if (rf_idx_s2_ep !== 3'd0 || rf_addr_s2_ep !== 7'd0) begin
            failures++;
            $display("FAIL nowr_s2 got %0d/%0d want 0/0", rf_addr_s2_ep, rf_idx_s2_ep);
        end
        checks++;
        if (rf_addr_s1_ep !== 7'd0 || rf_idx_s1_ep !== 3'd2) begin
            failures++;
            $display("FAIL r0_s1 got %0d/%0d want 0/2", rf_addr_s1_ep, rf_idx_s1_ep);
        end
        tick(5);
        checks++;
        if (wb_en_ep !== 1'b0) begin
            failures++;
            $display("FAIL nowr_wb got %b want 0", wb_en_ep);
        end
        tick(1);
        checks++;
        if (wb_en_ep !== 1'b1 || wb_addr_ep !== 7'd0) begin
            failures++;
            $display("FAIL r0_wb got %b/%0d want 1/0", wb_en_ep, wb_addr_ep);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        test_reset();
        test_single();
        test_flush();
        test_idx_err();
        test_waw();
        test_back_to_back();
        test_no_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
